// File: rtl/i2c_reg_slave.sv
// I2C target with a DEPTH x 8 register file. A write loads a register pointer and then
// stores bytes; a read returns bytes from the pointer. Both auto-increment the pointer.
module i2c_reg_slave #(
    parameter logic [6:0] ADDR  = 7'h52,
    parameter int         DEPTH = 16,
    localparam int        PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scl,
    inout  wire           sda,
    input  logic          host_we,
    input  logic [PW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          wr_strobe,
    output logic [PW-1:0] wr_index,
    output logic [7:0]    wr_data,
    output logic          busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
    } state_e;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic [7:0]    shift_q;
    logic [PW-1:0] ptr_q;
    logic          sda_oe_q;
    logic          busy_q;
    logic          strobe_q;
    logic [PW-1:0] wr_index_q;
    logic [7:0]    wr_data_q;
    logic [7:0]    regs_q [DEPTH];
    // Bit [0] is the first sync stage, [1] the synchronised value, [2] its history.
    logic [2:0]    scl_sync_q;
    logic [2:0]    sda_sync_q;

    logic          scl_rise_s;
    logic          scl_fall_s;
    logic          scl_high_s;
    logic          start_s;
    logic          stop_s;
    logic          commit_s;
    logic [7:0]    byte_s;
    logic [PW-1:0] ptr_d;

    assign scl_rise_s = scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall_s = ~scl_sync_q[1] & scl_sync_q[2];
    assign scl_high_s = scl_sync_q[1] & scl_sync_q[2];
    assign start_s    = scl_high_s & sda_sync_q[2] & ~sda_sync_q[1];
    assign stop_s     = scl_high_s & ~sda_sync_q[2] & sda_sync_q[1];
    assign byte_s     = {shift_q[6:0], sda_sync_q[1]};
    assign commit_s   = (state_q == S_WDATA) && scl_rise_s && (cnt_q == 4'd7);
    assign ptr_d      = ptr_q + {{(PW-1){1'b0}}, 1'b1};

    assign sda        = sda_oe_q ? 1'b0 : 1'bz;
    assign host_rdata = regs_q[host_addr];
    assign wr_strobe  = strobe_q;
    assign wr_index   = wr_index_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;

    // Bus line synchronisers; idle bus level is high so reset to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], scl};
            sda_sync_q <= {sda_sync_q[1:0], sda};
        end
    end

    // Register file: the bus commit wins over a host write to the same index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            if (host_we && !(commit_s && (host_addr == ptr_q))) begin
                regs_q[host_addr] <= host_wdata;
            end
            if (commit_s) begin
                regs_q[ptr_q] <= byte_s;
            end
        end
    end

    // Protocol FSM; sda only changes on a synchronised scl fall (or START/STOP/reset release).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'h00;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            strobe_q   <= 1'b0;
            wr_index_q <= '0;
            wr_data_q  <= 8'h00;
        end else begin
            strobe_q <= 1'b0;
            if (stop_s) begin
                state_q  <= S_IDLE;
                cnt_q    <= 4'd0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (start_s) begin
                state_q  <= S_ADDR;
                cnt_q    <= 4'd0;
                sda_oe_q <= 1'b0;
            end else begin
                case (state_q)
                    S_ADDR, S_PTR, S_WDATA: begin
                        if (scl_rise_s) begin
                            shift_q <= byte_s;
                            if (cnt_q == 4'd7) begin
                                cnt_q <= 4'd8;
                                case (state_q)
                                    S_ADDR: begin
                                        if (byte_s[7:1] == ADDR) begin
                                            state_q <= S_ADDR_ACK;
                                            busy_q  <= 1'b1;
                                        end else begin
                                            state_q <= S_IGNORE;
                                        end
                                    end
                                    S_PTR: begin
                                        ptr_q   <= byte_s[PW-1:0];
                                        state_q <= S_PTR_ACK;
                                    end
                                    S_WDATA: begin
                                        strobe_q   <= 1'b1;
                                        wr_index_q <= ptr_q;
                                        wr_data_q  <= byte_s;
                                        ptr_q      <= ptr_d;
                                        state_q    <= S_WDATA_ACK;
                                    end
                                    default: state_q <= S_IGNORE;
                                endcase
                            end else begin
                                cnt_q <= cnt_q + 4'd1;
                            end
                        end
                    end
                    // cnt_q == 8 marks the low phase before the ACK clock, 0 the one after it.
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                        if (scl_rise_s) begin
                            cnt_q <= 4'd0;
                        end else if (scl_fall_s && (cnt_q == 4'd8)) begin
                            sda_oe_q <= 1'b1;
                        end else if (scl_fall_s) begin
                            if ((state_q == S_ADDR_ACK) && shift_q[0]) begin
                                shift_q  <= regs_q[ptr_q];
                                sda_oe_q <= ~regs_q[ptr_q][7];
                                state_q  <= S_RDATA;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= (state_q == S_ADDR_ACK) ? S_PTR : S_WDATA;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (scl_rise_s) begin
                            shift_q <= byte_s;
                            cnt_q   <= cnt_q + 4'd1;
                        end else if (scl_fall_s && (cnt_q == 4'd8)) begin
                            sda_oe_q <= 1'b0;
                            ptr_q    <= ptr_d;
                            state_q  <= S_RDATA_ACK;
                        end else if (scl_fall_s) begin
                            sda_oe_q <= ~shift_q[7];
                        end
                    end
                    S_RDATA_ACK: begin
                        if (scl_rise_s) begin
                            if (sda_sync_q[1]) begin
                                state_q <= S_IGNORE;
                            end else begin
                                cnt_q <= 4'd0;
                            end
                        end else if (scl_fall_s && (cnt_q == 4'd0)) begin
                            shift_q  <= regs_q[ptr_q];
                            sda_oe_q <= ~regs_q[ptr_q][7];
                            state_q  <= S_RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_reg_slave.md
Name: i2c_reg_slave

Overview:
- I2C target (responder) with an internal 16x8 register file, built for the bus the i2c_master/i2c_slave pair uses.
- A write transaction loads a register pointer and then writes registers with pointer auto-increment.
- A read transaction returns registers from the current pointer, also auto-incrementing.
- A host-side port lets the bench or system logic preload and observe registers, and pulses a strobe on every bus write.

Parameters:
- ADDR, 7'h52, 7-bit I2C device address the block answers to.
- DEPTH, 16, register count; power of two; pointer width PW = log2(DEPTH).

Ports:
- clk  in  1  system clock; must be at least 8x the SCL rate.
- reset  in  1  asynchronous, active-high reset.
- scl  in  1  bus clock; the block never stretches it.
- sda  inout  1  open-drain data; driven to 0 or released (z), never driven to 1.
- host_we  in  1  host register write enable.
- host_addr  in  PW  host register index for write and readback.
- host_wdata  in  8  host write data.
- host_rdata  out  8  combinational readback of reg[host_addr].
- wr_strobe  out  1  one-clk pulse when a bus data byte is committed.
- wr_index  out  PW  register written, valid with wr_strobe.
- wr_data  out  8  byte written, valid with wr_strobe.
- busy  out  1  high from a START that addresses this block until STOP.

Behaviour:
- **Reset values:** all registers 0, pointer 0, state IDLE, sda released, wr_strobe 0, wr_index 0, wr_data 0, busy 0. Asserting reset mid-transfer releases sda in the same cycle, with no wait for clk.
- **Synchronisers:** scl and sda each pass through a 2-flop synchroniser plus one history flop. Edge detection uses the synchronised values only.
- **START:** sda falls while scl is high. Legal in any state, including repeated START; the state goes to ADDR and the bit counter clears. The pointer is kept across a repeated START.
- **STOP:** sda rises while scl is high. State goes to IDLE, sda is released, busy goes to 0.
- **Bit timing:**
  - Input bits are sampled on the synchronised scl rising edge, MSB first.
  - The block changes sda only in the clk after a synchronised scl falling edge.
- **FSM states:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- **ADDR:** shift in 8 bits.
  - Bits [7:1] equal ADDR: go to ADDR_ACK and set busy.
  - Otherwise: go to IGNORE. sda stays released (NACK) until the next START or STOP.
- **ADDR_ACK:** drive sda low from the falling edge after bit 8 to the falling edge after the 9th clock. Then:
  - R/W = 0 goes to PTR.
  - R/W = 1 goes to RDATA. reg[pointer] is loaded into the shift register at that falling edge, and bit 7 is driven at once.
- **PTR:** shift in 8 bits; pointer <= byte[PW-1:0] (upper bits ignored); ACK in PTR_ACK; then go to WDATA.
- **WDATA:** shift in 8 bits. On the 8th rising edge:
  - reg[pointer] <= byte.
  - wr_strobe pulses for 1 clk, with wr_index = pointer and wr_data = byte.
  - pointer <= pointer + 1, wrapping from DEPTH-1 to 0.
  - Then ACK in WDATA_ACK and return to WDATA.
- **RDATA:**
  - The block drives sda low for 0 bits and releases it for 1 bits.
  - After bit 8 it releases sda, goes to RDATA_ACK, and increments the pointer with wrap.
- **RDATA_ACK:** sample sda at the 9th rising edge.
  - 0 (ACK): load the next reg[pointer] and continue RDATA.
  - 1 (NACK): go to IGNORE, which waits for STOP or START.
- **Collision:** if host_we and a bus commit hit the same register in the same clk, the bus write wins. A host write to a different register takes effect normally.
- **Out-of-order STOP/START:** a STOP or START mid-byte aborts the byte. A partial byte is never committed and the pointer is unchanged.
- **No glitch on data bits:** sda changes caused by the block itself while scl is high are impossible by construction.

Test Plan:
- **Write:** START, 0xA4 (0x52 W), ptr 0x03, 0xA5, 0x5A, STOP.
  - All four bytes ACKed.
  - reg[3] = A5, reg[4] = 5A.
  - wr_strobe pulses twice: (3, A5) then (4, 5A).
  - busy falls after STOP.
- **Read with repeated START:** after the write above, START, 0xA4, ptr 0x03, repeated START, 0xA5 (read), master ACK then NACK.
  - Master receives A5 then 5A.
  - Pointer ends at 5.
- **Wrap:** write ptr 0x0F, data 0x11, 0x22.
  - reg[15] = 11, reg[0] = 22, pointer = 1.
  - Pointer byte 0xF3 selects reg[3].
- **Foreign address:** START, 0xA0 (0x50 W), 0xFF, STOP.
  - sda never driven low by this block.
  - No wr_strobe, registers unchanged, busy stays 0.
- **Host port and collision:**
  - host_we writes reg[7] = 0x3C; a bus read from ptr 7 returns 0x3C.
  - With host_we and a bus commit to reg[2] in the same clk (host 0x01, bus 0x02), reg[2] = 0x02.
- **Reset mid-read:** assert reset while driving a 0 bit of 0x00.
  - sda is z in the same cycle and all outputs are at reset values.
  - A fresh write transaction afterwards succeeds.
